pcie_wr_scheduler: RTL and testbench

Schedules host-memory ring writes for two on-chip requesters, the interrupt request queue (IRRQ) and the completion queue (CQ), onto the single PCIe write master port. Each accepted 56-bit record is written as one 2-beat entry into a per-source ring buffer in host memory. The block owns ring base/producer/consumer state, programmed through the 8-bit-address configuration slave. Arbitration is round-robin at entry granularity, and beats from different entries never interleave.

---
 rtl/pcie_wr_scheduler_if.sv | 39 +++
 rtl/pcie_wr_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_pcie_wr_scheduler.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_wr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pcie_wr_scheduler_if
// Description : Bus bundle for pcie_wr_scheduler. Carries the PCIe write
//               master port (Arb*) and the two requester handshakes
//               (IRRQ and CQ record valid/ready/info).
//   master : scheduler side - drives Arb* outputs and requester readys
//   slave  : environment side - drives ArbWaitRequest and requester records
// Revision    : 1.0 - initial release
// ============================================================================
interface pcie_wr_scheduler_if;
  logic        ArbChipSelect;
  logic        ArbWrite;
  logic [63:0] ArbAddress;
  logic [31:0] ArbWriteData;
  logic [3:0]  ArbByteEnable;
  logic        ArbWaitRequest;
  logic        irrqValid;
  logic [55:0] irrqInfo;
  logic        irrqReady;
  logic        cqValid;
  logic [55:0] cqInfo;
  logic        cqReady;

  modport master (
    output ArbChipSelect, ArbWrite, ArbAddress, ArbWriteData, ArbByteEnable,
    input  ArbWaitRequest,
    input  irrqValid, irrqInfo, cqValid, cqInfo,
    output irrqReady, cqReady
  );

  modport slave (
    input  ArbChipSelect, ArbWrite, ArbAddress, ArbWriteData, ArbByteEnable,
    output ArbWaitRequest,
    output irrqValid, irrqInfo, cqValid, cqInfo,
    input  irrqReady, cqReady
  );
endinterface
`default_nettype wire

// File: rtl/pcie_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pcie_wr_scheduler
// Description : Writes 56-bit records from two requesters (IRRQ, CQ) as
//               2-beat 8-byte entries into per-source host-memory rings over
//               one PCIe write master. Round-robin at entry granularity; the
//               two beats of an entry are never interleaved with another.
// Ports       :
//   clock, reset          core clock, asynchronous active-low reset
//   Conf*_i / Conf*_o     8-bit-address config slave (CTRL, ring base,
//                         consumer and producer indices)
//   bus (master modport)  Arb* write master and irrq/cq valid/ready/info
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_wr_scheduler #(
  parameter int IDX_W = 4
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        ConfChipSelect_i,
  input  wire logic        ConfWrite_i,
  input  wire logic        ConfRead_i,
  input  wire logic [7:0]  ConfAddress_i,
  input  wire logic [31:0] ConfWriteData_i,
  input  wire logic [3:0]  ConfByteEnable_i,
  output logic             ConfWaitRequest_o,
  output logic [31:0]      ConfReadData_o,
  pcie_wr_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  // Reads are combinational on select and byte enables are ignored.
  wire unused_ok = &{1'b0, ConfRead_i, ConfByteEnable_i};

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  logic [1:0]       ctrl_q;
  logic [31:0]      irrq_base_hi_q, irrq_base_lo_q;
  logic [31:0]      cq_base_hi_q, cq_base_lo_q;
  logic [IDX_W-1:0] irrq_cons_q, cq_cons_q;
  logic [IDX_W-1:0] irrq_prod_q, cq_prod_q;
  logic [IDX_W-1:0] irrq_prod_d, cq_prod_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_q         <= '0;
      irrq_base_hi_q <= '0;
      irrq_base_lo_q <= '0;
      irrq_cons_q    <= '0;
      cq_base_hi_q   <= '0;
      cq_base_lo_q   <= '0;
      cq_cons_q      <= '0;
    end else if (ConfChipSelect_i && ConfWrite_i) begin
      case (ConfAddress_i)
        8'h00:   ctrl_q         <= ConfWriteData_i[1:0];
        8'h10:   irrq_base_hi_q <= ConfWriteData_i;
        8'h14:   irrq_base_lo_q <= ConfWriteData_i;
        8'h18:   irrq_cons_q    <= ConfWriteData_i[IDX_W-1:0];
        8'h20:   cq_base_hi_q   <= ConfWriteData_i;
        8'h24:   cq_base_lo_q   <= ConfWriteData_i;
        8'h28:   cq_cons_q      <= ConfWriteData_i[IDX_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    ConfReadData_o = '0;
    if (ConfChipSelect_i) begin
      case (ConfAddress_i)
        8'h00:   ConfReadData_o = {30'd0, ctrl_q};
        8'h10:   ConfReadData_o = irrq_base_hi_q;
        8'h14:   ConfReadData_o = irrq_base_lo_q;
        8'h18:   ConfReadData_o = 32'(irrq_cons_q);
        8'h1C:   ConfReadData_o = 32'(irrq_prod_q);
        8'h20:   ConfReadData_o = cq_base_hi_q;
        8'h24:   ConfReadData_o = cq_base_lo_q;
        8'h28:   ConfReadData_o = 32'(cq_cons_q);
        8'h2C:   ConfReadData_o = 32'(cq_prod_q);
        default: ConfReadData_o = '0;
      endcase
    end
  end

  assign ConfWaitRequest_o = 1'b0;

  // --------------------------------------------------------------------------
  // Eligibility and round-robin grant
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic        last_cq_q;   // 1 when the most recent grant went to CQ
  logic        src_cq_q;    // source of the entry in flight
  logic [31:0] info_lo_q;   // second-beat payload
  logic        cs_q;
  logic [63:0] addr_q;
  logic [31:0] data_q;

  // Index arithmetic wraps naturally at IDX_W bits.
  assign irrq_prod_d = irrq_prod_q + IDX_W'(1);
  assign cq_prod_d   = cq_prod_q + IDX_W'(1);

  logic irrq_elig, cq_elig, gnt_irrq, gnt_cq;
  assign irrq_elig = bus.irrqValid & ctrl_q[0] & (irrq_prod_d != irrq_cons_q);
  assign cq_elig   = bus.cqValid   & ctrl_q[1] & (cq_prod_d   != cq_cons_q);

  assign gnt_irrq = (state_q == IDLE) & irrq_elig & (~cq_elig   |  last_cq_q);
  assign gnt_cq   = (state_q == IDLE) & cq_elig   & (~irrq_elig | ~last_cq_q);

  assign bus.irrqReady = gnt_irrq;
  assign bus.cqReady   = gnt_cq;

  // Slot address: base (low 3 bits ignored) plus 8 bytes per producer index.
  logic [63:0] irrq_entry, cq_entry, sel_entry;
  logic [55:0] sel_info;
  assign irrq_entry = {irrq_base_hi_q, irrq_base_lo_q[31:3], 3'b000}
                    + 64'({irrq_prod_q, 3'b000});
  assign cq_entry   = {cq_base_hi_q, cq_base_lo_q[31:3], 3'b000}
                    + 64'({cq_prod_q, 3'b000});
  assign sel_entry  = gnt_cq ? cq_entry : irrq_entry;
  assign sel_info   = gnt_cq ? bus.cqInfo : bus.irrqInfo;

  // --------------------------------------------------------------------------
  // Entry FSM with registered master outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_cq_q   <= 1'b1;
      src_cq_q    <= 1'b0;
      info_lo_q   <= '0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      irrq_prod_q <= '0;
      cq_prod_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_irrq || gnt_cq) begin
            src_cq_q  <= gnt_cq;
            last_cq_q <= gnt_cq;
            info_lo_q <= sel_info[31:0];
            cs_q      <= 1'b1;
            addr_q    <= sel_entry;
            data_q    <= {8'h00, sel_info[55:32]};
            state_q   <= BEAT0;
          end
        end
        BEAT0: begin
          if (!bus.ArbWaitRequest) begin
            addr_q  <= addr_q + 64'd4;
            data_q  <= info_lo_q;
            state_q <= BEAT1;
          end
        end
        BEAT1: begin
          if (!bus.ArbWaitRequest) begin
            cs_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            state_q <= IDLE;
            // Producer advances even if the source was disabled mid-entry.
            if (src_cq_q) cq_prod_q   <= cq_prod_d;
            else          irrq_prod_q <= irrq_prod_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ArbChipSelect = cs_q;
  assign bus.ArbWrite      = cs_q;
  assign bus.ArbByteEnable = {4{cs_q}};
  assign bus.ArbAddress    = addr_q;
  assign bus.ArbWriteData  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_wr_scheduler
// Description : Self-checking bench for pcie_wr_scheduler. A ring/queue model
//               predicts grants and the expected beat stream; one negedge
//               process compares the DUT against it every cycle, and directed
//               scenarios pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_wr_scheduler;
  localparam int IDX_W = 4;
  localparam int RING  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ConfChipSelect_i = 1'b0;
  logic        ConfWrite_i = 1'b0;
  logic        ConfRead_i = 1'b0;
  logic [7:0]  ConfAddress_i = 8'h00;
  logic [31:0] ConfWriteData_i = 32'h0;
  logic [3:0]  ConfByteEnable_i = 4'hf;
  logic        ConfWaitRequest_o;
  logic [31:0] ConfReadData_o;

  always #5 clock = ~clock;

  pcie_wr_scheduler_if bus ();

  pcie_wr_scheduler #(.IDX_W(IDX_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .ConfChipSelect_i  (ConfChipSelect_i),
    .ConfWrite_i       (ConfWrite_i),
    .ConfRead_i        (ConfRead_i),
    .ConfAddress_i     (ConfAddress_i),
    .ConfWriteData_i   (ConfWriteData_i),
    .ConfByteEnable_i  (ConfByteEnable_i),
    .ConfWaitRequest_o (ConfWaitRequest_o),
    .ConfReadData_o    (ConfReadData_o),
    .bus               (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed { logic [63:0] a; logic [31:0] d; } beat_t;
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  int          m_cons [2];
  int          m_prod [2];
  logic [1:0]  m_en;
  int          m_last;     // 0 = IRRQ, 1 = CQ
  int          m_src;
  beat_t       m_q [$];    // beats still owed for the accepted entry

  logic [63:0] log_a [$];
  logic [31:0] log_d [$];
  int          acc_src [$];
  int          acc_cyc [$];
  int          done_cyc = 0;
  int          cyc = 0;
  logic        acc_i = 1'b0, acc_c = 1'b0;

  logic [55:0] pend_i [$];
  logic [55:0] pend_c [$];
  int          gap_pct = 0;
  int          wait_mode = 0;   // 0 manual, 1 random
  logic        wait_manual = 1'b0;

  logic [7:0]  regs [9] = '{8'h00, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C};

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {30'd0, m_en};
      8'h10:   return m_hi[0];
      8'h14:   return m_lo[0];
      8'h18:   return 32'(m_cons[0]);
      8'h1C:   return 32'(m_prod[0]);
      8'h20:   return m_hi[1];
      8'h24:   return m_lo[1];
      8'h28:   return 32'(m_cons[1]);
      8'h2C:   return 32'(m_prod[1]);
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clock) begin : compare
    logic [1:0]  v, el, g;
    logic        busy;
    int          s;
    logic [55:0] inf;
    logic [63:0] a;
    cyc++;
    acc_i = bus.irrqValid & bus.irrqReady;
    acc_c = bus.cqValid & bus.cqReady;
    if (!reset) begin
      m_en = 2'b00; m_last = 1;
      for (int k = 0; k < 2; k++) begin
        m_hi[k] = 0; m_lo[k] = 0; m_cons[k] = 0; m_prod[k] = 0;
      end
      m_q.delete();
      chk("rst_cs", bus.ArbChipSelect, 0);
      chk("rst_be", bus.ArbByteEnable, 0);
      chk("rst_addr", bus.ArbAddress, 0);
      chk("rst_data", bus.ArbWriteData, 0);
      chk("rst_ready", {bus.irrqReady, bus.cqReady}, 0);
    end else begin
      v    = {bus.cqValid, bus.irrqValid};
      busy = (m_q.size() != 0);
      for (int k = 0; k < 2; k++)
        el[k] = v[k] & m_en[k] & (((m_prod[k] + 1) % RING) != m_cons[k]);
      g = 2'b00;
      if (!busy) begin
        if (el == 2'b11) g[1 - m_last] = 1'b1;
        else             g = el;
      end
      chk("irrq_ready", bus.irrqReady, g[0]);
      chk("cq_ready", bus.cqReady, g[1]);
      chk("arb_cs", bus.ArbChipSelect, busy);
      chk("arb_write", bus.ArbWrite, bus.ArbChipSelect);
      chk("arb_be", bus.ArbByteEnable, busy ? 4'hf : 4'h0);
      chk("conf_wait", ConfWaitRequest_o, 0);
      if (busy) begin
        chk("arb_addr", bus.ArbAddress, m_q[0].a);
        chk("arb_data", bus.ArbWriteData, m_q[0].d);
        if (!bus.ArbWaitRequest) begin
          log_a.push_back(bus.ArbAddress);
          log_d.push_back(bus.ArbWriteData);
          m_q.delete(0);
          if (m_q.size() == 0) begin
            m_prod[m_src] = (m_prod[m_src] + 1) % RING;
            done_cyc = cyc + 1;
          end
        end
      end
      if (g != 2'b00) begin
        s   = g[1] ? 1 : 0;
        inf = s ? bus.cqInfo : bus.irrqInfo;
        a   = {m_hi[s], m_lo[s][31:3], 3'b000} + 64'(m_prod[s] * 8);
        m_q.push_back('{a: a,         d: {8'h00, inf[55:32]}});
        m_q.push_back('{a: a + 64'd4, d: inf[31:0]});
        m_src = s; m_last = s;
        acc_src.push_back(s);
        acc_cyc.push_back(cyc);
      end
      if (ConfChipSelect_i && ConfWrite_i) begin
        case (ConfAddress_i)
          8'h00: m_en = ConfWriteData_i[1:0];
          8'h10: m_hi[0] = ConfWriteData_i;
          8'h14: m_lo[0] = ConfWriteData_i;
          8'h18: m_cons[0] = int'(ConfWriteData_i[IDX_W-1:0]);
          8'h20: m_hi[1] = ConfWriteData_i;
          8'h24: m_lo[1] = ConfWriteData_i;
          8'h28: m_cons[1] = int'(ConfWriteData_i[IDX_W-1:0]);
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  initial begin : drv_irrq
    bus.irrqValid = 1'b0; bus.irrqInfo = '0;
    forever begin
      @(posedge clock); #1;
      if (acc_i && pend_i.size() > 0) pend_i.delete(0);
      if (bus.irrqValid && !acc_i) ;  // hold until accepted
      else if (pend_i.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        bus.irrqValid = 1'b1; bus.irrqInfo = pend_i[0];
      end else bus.irrqValid = 1'b0;
    end
  end

  initial begin : drv_cq
    bus.cqValid = 1'b0; bus.cqInfo = '0;
    forever begin
      @(posedge clock); #1;
      if (acc_c && pend_c.size() > 0) pend_c.delete(0);
      if (bus.cqValid && !acc_c) ;
      else if (pend_c.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        bus.cqValid = 1'b1; bus.cqInfo = pend_c[0];
      end else bus.cqValid = 1'b0;
    end
  end

  initial begin : drv_wait
    bus.ArbWaitRequest = 1'b0;
    forever begin
      @(posedge clock); #2;
      bus.ArbWaitRequest = (wait_mode == 1) ? ($urandom_range(0, 2) == 0) : wait_manual;
    end
  end

  // ---------------------------------------------------------------- helpers
  // Callers sit just after a rising edge.
  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    ConfChipSelect_i = 1'b1; ConfWrite_i = 1'b1; ConfAddress_i = a; ConfWriteData_i = d;
    @(posedge clock); #1;
    ConfChipSelect_i = 1'b0; ConfWrite_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    ConfChipSelect_i = 1'b1; ConfRead_i = 1'b1; ConfAddress_i = a;
    #1 d = ConfReadData_o;
    ConfChipSelect_i = 1'b0; ConfRead_i = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((pend_i.size() != 0 || pend_c.size() != 0 || m_q.size() != 0 ||
            bus.irrqValid || bus.cqValid) && n < maxc) begin
      @(posedge clock); n++;
    end
    n_tests++;
    if (n >= maxc) begin
      n_fail++;
      $display("FAIL drain_timeout: busy after %0d cycles, required idle", n);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic wait_cs(input int maxc);
    int n = 0;
    while (!bus.ArbChipSelect && n < maxc) begin
      @(posedge clock); #1; n++;
    end
    n_tests++;
    if (!bus.ArbChipSelect) begin
      n_fail++;
      $display("FAIL cs_timeout: ArbChipSelect 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic clear_logs();
    log_a.delete(); log_d.delete(); acc_src.delete(); acc_cyc.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- main
  initial begin : main
    logic [31:0] rd;
    int r;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    @(posedge clock); #1;

    foreach (regs[k]) begin
      cfg_read(regs[k], rd);
      chk("reset_reg", rd, 32'h0);
    end

    // single IRRQ record at base 0x1_0000_0000
    cfg_write(8'h10, 32'h1);
    cfg_write(8'h14, 32'h0);
    cfg_write(8'h00, 32'h1);
    clear_logs();
    pend_i.push_back(56'hAB_CDEF_1234_5678);
    wait_drain(50);
    chk("t1_nbeats", log_a.size(), 2);
    chk("t1_a0", log_a[0], 64'h1_0000_0000);
    chk("t1_d0", log_d[0], 32'h00AB_CDEF);
    chk("t1_a1", log_a[1], 64'h1_0000_0004);
    chk("t1_d1", log_d[1], 32'h1234_5678);
    cfg_read(8'h1C, rd);
    chk("t1_prod", rd, 32'h1);

    // both sources saturated: strict alternation, 3 cycles per entry
    cfg_write(8'h20, 32'h0);
    cfg_write(8'h24, 32'h8000);
    cfg_write(8'h00, 32'h3);
    clear_logs();
    for (int k = 0; k < 6; k++) begin
      pend_i.push_back({24'($urandom), $urandom});
      pend_c.push_back({24'($urandom), $urandom});
    end
    wait_drain(200);
    chk("t2_naccept", acc_src.size(), 12);
    chk("t2_first_cq", acc_src[0], 1);
    for (int k = 1; k < 12; k++) begin
      chk("t2_alt", acc_src[k], 1 - acc_src[k-1]);
      chk("t2_gap", acc_cyc[k] - acc_cyc[k-1], 3);
    end

    // stalls: 5 cycles in BEAT0, 2 in BEAT1
    clear_logs();
    pend_i.push_back(56'h11_2233_4455_6677);
    wait_cs(20);
    wait_manual = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    wait_manual = 1'b0;
    @(posedge clock); #1;
    wait_manual = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    wait_manual = 1'b0;
    wait_drain(30);
    chk("t3_naccept", acc_cyc.size(), 1);
    chk("t3_latency", done_cyc - acc_cyc[0], 10);
    chk("t3_d1", log_d[1], 32'h4455_6677);

    // randomized traffic, stalls and config activity
    wait_mode = 1;
    gap_pct = 30;
    repeat (400) begin
      r = $urandom_range(0, 11);
      case (r)
        0: cfg_write($urandom_range(0, 1) ? 8'h18 : 8'h28, $urandom);
        1: cfg_write(8'h00, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h3);
        2: cfg_write($urandom_range(0, 1) ? 8'h14 : 8'h24, $urandom);
        3: cfg_write($urandom_range(0, 1) ? 8'h10 : 8'h20, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
        4: begin
          logic [7:0] ra;
          ra = regs[$urandom_range(0, 8)];
          cfg_read(ra, rd);
          chk("rand_read", rd, m_read(ra));
          @(posedge clock); #1;
        end
        5: cfg_write(($urandom_range(0, 1) ? 8'h1C : 8'h2C) ^ (($urandom_range(0, 1)) ? 8'h00 : 8'h30), $urandom);
        default: begin
          if (pend_i.size() < 4 && $urandom_range(0, 1)) pend_i.push_back({24'($urandom), $urandom});
          if (pend_c.size() < 4 && $urandom_range(0, 1)) pend_c.push_back({24'($urandom), $urandom});
          @(posedge clock); #1;
        end
      endcase
    end
    wait_mode = 0;
    gap_pct = 0;
    cfg_write(8'h00, 32'h3);
    cfg_write(8'h18, 32'(m_prod[0]));
    cfg_write(8'h28, 32'(m_prod[1]));
    wait_drain(400);

    // asynchronous reset during BEAT1
    pend_i.push_back(56'h00_0000_DEAD_BEEF);
    wait_cs(20);
    @(posedge clock); #3;
    chk("t5_pre_cs", bus.ArbChipSelect, 1);
    reset = 1'b0;
    #1;
    chk("t5_async_cs", bus.ArbChipSelect, 0);
    chk("t5_async_addr", bus.ArbAddress, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    @(posedge clock); #1;
    foreach (regs[k]) begin
      cfg_read(regs[k], rd);
      chk("t5_reg_zero", rd, 32'h0);
    end

    // base rewrite while the first entry is in BEAT0
    cfg_write(8'h10, 32'h0);
    cfg_write(8'h14, 32'h100);
    cfg_write(8'h00, 32'h1);
    clear_logs();
    pend_i.push_back({24'($urandom), $urandom});
    pend_i.push_back({24'($urandom), $urandom});
    wait_cs(20);
    cfg_write(8'h14, 32'h2000);
    wait_drain(40);
    chk("t6_nbeats", log_a.size(), 4);
    chk("t6_old_base", log_a[0], 64'h100);
    chk("t6_new_base", log_a[2], 64'h2008);

    // CQ ring full, then release by consumer update, then wrap
    cfg_write(8'h00, 32'h2);
    cfg_write(8'h24, 32'h4000);
    clear_logs();
    for (int k = 0; k < 16; k++) pend_c.push_back({24'($urandom), $urandom});
    repeat (80) @(posedge clock);
    #1;
    chk("t7_naccept_full", acc_src.size(), 15);
    chk("t7_pending", pend_c.size(), 1);
    cfg_read(8'h2C, rd);
    chk("t7_prod_full", rd, 32'd15);
    cfg_write(8'h28, 32'h1);
    wait_drain(30);
    chk("t7_naccept", acc_src.size(), 16);
    chk("t7_slot15", log_a[30], 64'h4078);
    cfg_read(8'h2C, rd);
    chk("t7_prod_wrap", rd, 32'h0);
    cfg_write(8'h28, 32'h2);
    pend_c.push_back({24'($urandom), $urandom});
    wait_drain(30);
    chk("t7_slot0", log_a[32], 64'h4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
